cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates the instruction cache and data cache of the pipelined LC-3b for a single shared line-wide physical-memory (or L2) port. It sits between the two L1 cache controllers and memory. It captures one requester's line transaction, drives it to memory, and routes the response back. Ties are broken round-robin so neither requester starves.

## Interface
- LINE_WIDTH, 128, cache line width in bits
- ADDR_WIDTH, 16, byte address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  read line to I-cache
- i_resp  out  1  I-cache transaction complete, one-cycle pulse
- d_read  in  1  D-cache line read request, level
- d_write  in  1  D-cache line write-back request, level
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache write-back line
- d_rdata  out  LINE_WIDTH  read line to D-cache
- d_resp  out  1  D-cache transaction complete, one-cycle pulse
- mem_read  out  1  memory read strobe, held until mem_resp
- mem_write  out  1  memory write strobe, held until mem_resp
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data, valid with mem_resp
- mem_resp  in  1  memory transaction complete

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY. Separate 1-bit `last_grant` register: 0 = I, 1 = D.
- IDLE, only I requesting: go to I_BUSY. Latch i_address and read op into registers.
- IDLE, only D requesting: go to D_BUSY. Latch d_address, d_wdata and op.
- IDLE, both requesting: grant the side not equal to last_grant. Update last_grant to the side granted.
- d_read and d_write both high: illegal. The write is performed.
- I_BUSY / D_BUSY: mem_read or mem_write driven high from the latched op. mem_address and mem_wdata are driven from the latched registers.
- Inputs are not re-sampled while busy. Requester-side changes mid-transaction are ignored.
- On mem_resp while busy:
  - pulse the owner's resp combinationally in that same cycle;
  - route mem_rdata to that side's rdata;
  - next state IDLE; mem_read and mem_write drop at that edge.
- i_rdata and d_rdata are continuous copies of mem_rdata. They are valid only while the matching resp is high.
- i_resp = (state==I_BUSY) & mem_resp; d_resp = (state==D_BUSY) & mem_resp.
- mem_resp in IDLE is ignored.
- Fairness: a continuously asserted request waits at most one complete foreign transaction.

## Timing
- Reset values, rst high at edge:
  - state IDLE, last_grant 0;
  - mem_read 0, mem_write 0;
  - mem_address 0, mem_wdata 0, latched op registers 0;
  - i_resp and d_resp are 0 because state is IDLE.
- mem_read, mem_write, mem_address and mem_wdata are registered outputs.
- Latency: request seen in IDLE in cycle n; mem strobe high in cycle n+1. If mem_resp arrives in cycle k ≥ n+1, resp pulses in cycle k and the arbiter is IDLE in cycle k+1.
- Minimum occupancy is 2 cycles per transaction: grant plus a single-cycle memory response.
- Mandatory IDLE turnaround cycle after every completion. The requester has deasserted its request by then, so no re-grant of a finished request.
- Requester and arbiter requests arriving in the completion cycle are arbitrated in the following IDLE cycle.
- rst mid-transaction: state IDLE and strobes low at the next edge; no resp generated. A late mem_resp arriving in IDLE is dropped.
- No combinational path from i_read, d_read, d_write or addresses to mem_* outputs.

## Test plan
- Reset: hold rst 2 cycles with i_read=1 → mem_read=0, mem_address=0, i_resp=0 throughout. After release, mem_read=1 next cycle with mem_address=i_address.
- Single I read: i_address=0x1230, memory responds 3 cycles after the strobe with rdata=0xDEAD…BEEF → i_resp high exactly 1 cycle, i_rdata matches, d_resp=0, IDLE the following cycle.
- D write-back: d_write=1, d_address=0x8000, d_wdata=0xA5 repeated → mem_write=1 with matching address and data. d_resp pulses on mem_resp; mem_read never high.
- Simultaneous requests after reset: i_read and d_read both high from cycle 0 →
  - D served first (last_grant was 0), then I after one turnaround cycle;
  - a third tie is granted to D again;
  - no requester waits more than one foreign transaction.
- Mid-transaction input change: in I_BUSY, change i_address 0x1230→0x4440 → mem_address stays 0x1230 until completion.
- Reset mid-transaction plus late response: assert rst in D_BUSY, then pulse mem_resp in IDLE → d_resp and i_resp stay 0. The next request is handled normally.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Bus bundle shared by the I-cache, D-cache, arbiter and memory port.
// Parameters:
//   LINE_WIDTH - cache line width in bits
//   ADDR_WIDTH - byte address width
// Signal groups:
//   i_*   - I-cache side: read request, address, returned line, done pulse
//   d_*   - D-cache side: read/write-back request, address, data, done pulse
//   mem_* - shared memory port: strobes, address, write data, read data, done
// Modports:
//   slave  - the arbiter's view (takes cache requests, drives memory)
//   master - the environment's view (caches plus memory model)
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 16
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache line transactions onto one shared
// line-wide memory port. One transaction is captured at grant, driven to
// memory from registers, and the response is routed back to its owner.
// Ties are broken round-robin against last_grant.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - cache_arbiter_if.slave (cache request sides and memory port)
//
// state  | meaning
// IDLE   | no transaction; arbitrate requests seen this cycle
// I_BUSY | I-cache read in flight on the memory port
// D_BUSY | D-cache read or write-back in flight on the memory port
module cache_arbiter (
    input  logic             clk,
    input  logic             rst,
    cache_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t state, next_state;
    logic   last_grant, next_last_grant;   // 0 = I, 1 = D
    logic   grant_i, grant_d;
    logic   req_i, req_d;

    assign req_i = bus.i_read;
    assign req_d = bus.d_read | bus.d_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    // Tie: serve the side that was not granted last time.
                    grant_d         = ~last_grant;
                    grant_i         = last_grant;
                    next_last_grant = ~last_grant;
                end else begin
                    grant_i = req_i;
                    grant_d = req_d;
                end
                if (grant_i)      next_state = I_BUSY;
                else if (grant_d) next_state = D_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_resp) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Memory-side request registers; the strobes double as the latched op.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
        end else if (grant_i) begin
            bus.mem_read    <= 1'b1;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= bus.i_address;
        end else if (grant_d) begin
            // Read and write together is illegal; the write-back wins.
            bus.mem_read    <= ~bus.d_write;
            bus.mem_write   <= bus.d_write;
            bus.mem_address <= bus.d_address;
            bus.mem_wdata   <= bus.d_wdata;
        end else if (state != IDLE && bus.mem_resp) begin
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
        end
    end

    assign bus.i_resp  = (state == I_BUSY) & bus.mem_resp;
    assign bus.d_resp  = (state == D_BUSY) & bus.mem_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset, single I read, D write-back,
// illegal read+write, round-robin ties, mid-transaction address change,
// reset mid-transaction with a late memory response.
module tb_cache_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   failed = 0;

    cache_arbiter_if #(.LINE_WIDTH(128), .ADDR_WIDTH(16)) bus ();

    cache_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    localparam logic [127:0] RD_I = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] RD_D = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] WD_A5 = {16{8'hA5}};
    localparam logic [127:0] WD_5A = {8{16'h5A3C}};

    initial begin
        rst           = 1'b1;
        bus.i_read    = 1'b1;
        bus.i_address = 16'h1230;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = 16'h0000;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_resp  = 1'b0;

        // Reset held two edges with a pending I request
        step();
        check("rst1_mem_read", bus.mem_read, 0);
        check("rst1_mem_addr", bus.mem_address, 0);
        check("rst1_i_resp", bus.i_resp, 0);
        step();
        check("rst2_mem_read", bus.mem_read, 0);
        check("rst2_mem_write", bus.mem_write, 0);
        check("rst2_mem_addr", bus.mem_address, 0);
        check("rst2_mem_wdata", bus.mem_wdata, 0);
        rst = 1'b0;

        // Grant on the first edge after release
        step();
        check("i_grant_read", bus.mem_read, 1);
        check("i_grant_write", bus.mem_write, 0);
        check("i_grant_addr", bus.mem_address, 16'h1230);

        // Address change mid-transaction is ignored
        bus.i_address = 16'h4440;
        step();
        check("i_hold_addr1", bus.mem_address, 16'h1230);
        check("i_hold_resp", bus.i_resp, 0);
        step();
        check("i_hold_addr2", bus.mem_address, 16'h1230);
        step();
        check("i_hold_read3", bus.mem_read, 1);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = RD_I;
        #1;
        check("i_resp_pulse", bus.i_resp, 1);
        check("i_rdata", bus.i_rdata, RD_I);
        check("i_d_resp_quiet", bus.d_resp, 0);
        check("i_addr_at_resp", bus.mem_address, 16'h1230);
        bus.i_read = 1'b0;
        step();
        bus.mem_resp = 1'b0;
        #1;
        check("i_idle_read", bus.mem_read, 0);
        check("i_idle_resp", bus.i_resp, 0);

        // D write-back
        bus.d_write   = 1'b1;
        bus.d_address = 16'h8000;
        bus.d_wdata   = WD_A5;
        step();
        check("d_wr_write", bus.mem_write, 1);
        check("d_wr_read", bus.mem_read, 0);
        check("d_wr_addr", bus.mem_address, 16'h8000);
        check("d_wr_wdata", bus.mem_wdata, WD_A5);
        bus.mem_resp = 1'b1;
        #1;
        check("d_wr_resp", bus.d_resp, 1);
        check("d_wr_i_quiet", bus.i_resp, 0);
        check("d_wr_read_resp", bus.mem_read, 0);
        bus.d_write = 1'b0;
        step();
        bus.mem_resp = 1'b0;
        #1;
        check("d_wr_idle_write", bus.mem_write, 0);
        check("d_wr_idle_resp", bus.d_resp, 0);

        // Illegal read+write: write performed
        bus.d_read    = 1'b1;
        bus.d_write   = 1'b1;
        bus.d_address = 16'h8010;
        bus.d_wdata   = WD_5A;
        step();
        check("rw_write", bus.mem_write, 1);
        check("rw_read", bus.mem_read, 0);
        check("rw_wdata", bus.mem_wdata, WD_5A);
        bus.mem_resp = 1'b1;
        #1;
        check("rw_resp", bus.d_resp, 1);
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        step();
        bus.mem_resp = 1'b0;
        #1;
        check("rw_idle", bus.mem_write, 0);

        // Fresh reset so last_grant = 0, then continuous ties
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_read    = 1'b1;
        bus.i_address = 16'h1000;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h2000;
        step();
        check("tie1_read", bus.mem_read, 1);
        check("tie1_addr_d", bus.mem_address, 16'h2000);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = RD_D;
        #1;
        check("tie1_d_resp", bus.d_resp, 1);
        check("tie1_i_quiet", bus.i_resp, 0);
        check("tie1_d_rdata", bus.d_rdata, RD_D);
        step();
        bus.mem_resp = 1'b0;
        #1;
        check("tie1_turnaround", bus.mem_read, 0);
        step();
        check("tie2_read", bus.mem_read, 1);
        check("tie2_addr_i", bus.mem_address, 16'h1000);
        bus.mem_resp = 1'b1;
        #1;
        check("tie2_i_resp", bus.i_resp, 1);
        check("tie2_d_quiet", bus.d_resp, 0);
        step();
        bus.mem_resp = 1'b0;
        #1;
        check("tie2_turnaround", bus.mem_read, 0);
        step();
        check("tie3_addr_d", bus.mem_address, 16'h2000);
        check("tie3_read", bus.mem_read, 1);

        // Reset in D_BUSY, then a late response in IDLE
        rst        = 1'b1;
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        step();
        rst = 1'b0;
        check("midrst_read", bus.mem_read, 0);
        check("midrst_d_resp", bus.d_resp, 0);
        bus.mem_resp = 1'b1;
        #1;
        check("late_d_resp", bus.d_resp, 0);
        check("late_i_resp", bus.i_resp, 0);
        step();
        bus.mem_resp = 1'b0;
        #1;
        check("late_read", bus.mem_read, 0);
        check("late_write", bus.mem_write, 0);

        // Next request handled normally
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0040;
        step();
        check("post_read", bus.mem_read, 1);
        check("post_addr", bus.mem_address, 16'h0040);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = RD_I;
        #1;
        check("post_i_resp", bus.i_resp, 1);
        check("post_i_rdata", bus.i_rdata, RD_I);
        bus.i_read = 1'b0;
        step();
        bus.mem_resp = 1'b0;
        #1;
        check("post_idle", bus.mem_read, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
